// File: rtl/ldm_stm_sequencer_if.sv
// ldm_stm_sequencer_if
// Groups the block-transfer request, memory-side and register-file-side
// signals of the LDM/STM sequencer into one bundle.
//   master : the requesting side (drives start/list/base, observes bus outputs)
//   slave  : the sequencer itself
// Request  : start_in, load_in, pre_in, up_in, wb_in, reg_list_in, base_in, base_reg_in
// Memory   : addr_out, we_out, ctrl_load_mux_out, ctrl_str_mux_out
// Regfile  : reg_addr_out, reg_we_out, base_wb_out, base_we_out
// Status   : busy_out, done_out
interface ldm_stm_sequencer_if #(
    parameter int unsigned REG_LIST_W = 16
);
    logic                  start_in;
    logic                  load_in;
    logic                  pre_in;
    logic                  up_in;
    logic                  wb_in;
    logic [REG_LIST_W-1:0] reg_list_in;
    logic [31:0]           base_in;
    logic [3:0]            base_reg_in;

    logic [31:0]           addr_out;
    logic [3:0]            we_out;
    logic [2:0]            ctrl_load_mux_out;
    logic [2:0]            ctrl_str_mux_out;
    logic [3:0]            reg_addr_out;
    logic                  reg_we_out;
    logic [31:0]           base_wb_out;
    logic                  base_we_out;
    logic                  busy_out;
    logic                  done_out;

    modport master (
        output start_in, load_in, pre_in, up_in, wb_in, reg_list_in, base_in, base_reg_in,
        input  addr_out, we_out, ctrl_load_mux_out, ctrl_str_mux_out,
               reg_addr_out, reg_we_out, base_wb_out, base_we_out, busy_out, done_out
    );

    modport slave (
        input  start_in, load_in, pre_in, up_in, wb_in, reg_list_in, base_in, base_reg_in,
        output addr_out, we_out, ctrl_load_mux_out, ctrl_str_mux_out,
               reg_addr_out, reg_we_out, base_wb_out, base_we_out, busy_out, done_out
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
// Multi-cycle LDM/STM block-transfer sequencer. On start it captures the
// register list and base, then walks the list lowest register first, one
// word per cycle, optionally writes back the base, and pulses done.
// Ports:
//   clk_in    rising-edge clock
//   reset_in  asynchronous active-low reset
//   bus       ldm_stm_sequencer_if.slave (request, memory, regfile, status)
// Build option:
//   LSM_BASE_WB_EN  defined enables the base writeback (WB) state; when
//                   undefined W is ignored and base_wb_out/base_we_out are 0.
module ldm_stm_sequencer #(
    parameter int unsigned REG_LIST_W = 16
) (
    input  logic               clk_in,
    input  logic               reset_in,
    ldm_stm_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(REG_LIST_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    logic [REG_LIST_W-1:0] pending;
    logic [31:0]           addr_q;
    logic [3:0]            we_q;
    logic [3:0]            reg_addr_q;
    logic                  reg_we_q;
    logic                  busy_q;
    logic                  done_q;

`ifdef LSM_BASE_WB_EN
    logic                  wb_q;
    logic                  wb_allow_q;
    logic [31:0]           wb_val_q;
    logic [31:0]           base_wb_q;
    logic                  base_we_q;
`endif

    logic [CNT_W-1:0]      n_start;
    logic [31:0]           offset;
    logic [31:0]           start_addr;
    logic [3:0]            first_reg;
    logic [3:0]            next_reg;

    function automatic logic [CNT_W-1:0] popcount(input logic [REG_LIST_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < REG_LIST_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest(input logic [REG_LIST_W-1:0] v);
        logic [3:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < REG_LIST_W; i++) begin
            if (v[i] && !found) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    always_comb begin
        n_start   = popcount(bus.reg_list_in);
        offset    = 32'(n_start) << 2;
        first_reg = lowest(bus.reg_list_in);
        next_reg  = lowest(pending);
        // Decrementing modes start at the lowest address so the walk is
        // always ascending; only the starting point depends on P/U.
        case ({bus.pre_in, bus.up_in})
            2'b01:   start_addr = bus.base_in;
            2'b11:   start_addr = bus.base_in + 32'd4;
            2'b00:   start_addr = bus.base_in - offset + 32'd4;
            default: start_addr = bus.base_in - offset;
        endcase
        start_addr[1:0] = 2'b00;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state      <= IDLE;
            pending    <= '0;
            addr_q     <= '0;
            we_q       <= '0;
            reg_addr_q <= '0;
            reg_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LSM_BASE_WB_EN
            wb_q       <= 1'b0;
            wb_allow_q <= 1'b0;
            wb_val_q   <= '0;
            base_wb_q  <= '0;
            base_we_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        busy_q <= 1'b1;
`ifdef LSM_BASE_WB_EN
                        wb_q       <= bus.wb_in;
                        wb_allow_q <= !(bus.load_in && bus.reg_list_in[bus.base_reg_in]);
                        wb_val_q   <= bus.up_in ? (bus.base_in + offset) : (bus.base_in - offset);
`endif
                        if (n_start != '0) begin
                            // First register is issued on the capture edge so
                            // XFER lasts exactly n cycles.
                            state      <= XFER;
                            addr_q     <= start_addr;
                            reg_addr_q <= first_reg;
                            pending    <= bus.reg_list_in & (bus.reg_list_in - REG_LIST_W'(1));
                            we_q       <= bus.load_in ? 4'b0000 : 4'b1111;
                            reg_we_q   <= bus.load_in;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (pending == '0) begin
                        addr_q     <= '0;
                        reg_addr_q <= '0;
                        we_q       <= '0;
                        reg_we_q   <= 1'b0;
`ifdef LSM_BASE_WB_EN
                        if (wb_q) begin
                            state     <= WB;
                            base_we_q <= wb_allow_q;
                            base_wb_q <= wb_val_q;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
`else
                        state  <= DONE;
                        done_q <= 1'b1;
`endif
                    end else begin
                        addr_q     <= addr_q + 32'd4;
                        reg_addr_q <= next_reg;
                        pending    <= pending & (pending - REG_LIST_W'(1));
                    end
                end
                WB: begin
`ifdef LSM_BASE_WB_EN
                    base_we_q <= 1'b0;
                    base_wb_q <= '0;
`endif
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_out          = addr_q;
    assign bus.we_out            = we_q;
    assign bus.ctrl_load_mux_out = 3'b000;
    assign bus.ctrl_str_mux_out  = 3'b000;
    assign bus.reg_addr_out      = reg_addr_q;
    assign bus.reg_we_out        = reg_we_q;
    assign bus.busy_out          = busy_q;
    assign bus.done_out          = done_q;
`ifdef LSM_BASE_WB_EN
    assign bus.base_wb_out       = base_wb_q;
    assign bus.base_we_out       = base_we_q;
`else
    assign bus.base_wb_out       = '0;
    assign bus.base_we_out       = 1'b0;
`endif
endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter REG_LIST_W, default 16, SHALL set the register-list width, with one bit per architectural register.
REQ-002 clk_in  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset_in  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 start_in  input  1  SHALL request a block transfer; it is sampled only in IDLE.
REQ-005 load_in  input  1  SHALL select the transfer type: 1 = LDM (memory to registers), 0 = STM (registers to memory).
REQ-006 pre_in / up_in / wb_in  input  1 each  SHALL be the P, U and W instruction bits.
REQ-007 reg_list_in  input  REG_LIST_W  SHALL be the register list, captured at start.
REQ-008 base_in  input  32  SHALL be the base register value; base_reg_in  input  4  SHALL be the base register number.
REQ-009 addr_out  output  32  SHALL drive the data memory address.
REQ-010 we_out  output  4  SHALL drive the data memory byte write enables.
REQ-011 ctrl_load_mux_out / ctrl_str_mux_out  output  3 each  SHALL drive the data memory load/store format selects.
REQ-012 reg_addr_out  output  4  SHALL give the register currently being transferred (register-file read port for STM, write port for LDM).
REQ-013 reg_we_out  output  1  SHALL be the register-file write strobe for LDM data.
REQ-014 base_wb_out  output  32  SHALL carry the base writeback value; base_we_out  output  1  SHALL be its strobe.
REQ-015 busy_out  output  1  SHALL hold the pipeline stall; done_out  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, XFER, WB, DONE.
REQ-017 In IDLE with start_in=1, the block SHALL capture all inputs and compute n = popcount(reg_list_in); it goes to XFER if n>0, else to DONE.
REQ-018 The start address SHALL be, by (P,U): (0,1) base; (1,1) base+4; (0,0) base-4n+4; (1,0) base-4n; bits [1:0] are forced to 00.
REQ-019 XFER SHALL service one register per cycle, lowest-numbered set bit first, with the address incrementing by 4 each cycle regardless of U.
REQ-020 XFER SHALL last exactly n cycles; the pending-list bit is cleared as each register is serviced.
REQ-021 In XFER during STM, we_out SHALL be 4'b1111 and reg_we_out SHALL be 0; during LDM, we_out SHALL be 4'b0000 and reg_we_out SHALL be 1, with read data valid in the same cycle.
REQ-022 ctrl_load_mux_out and ctrl_str_mux_out SHALL be 3'b000 (word) in every state.
REQ-023 After the last XFER cycle, the block SHALL go to WB if the writeback feature is enabled and W=1, otherwise to DONE.
REQ-024 WB SHALL last one cycle, with base_we_out=1 and base_wb_out = base+4n if U=1, or base-4n if U=0.
REQ-025 Under LDM, if reg_list bit[base_reg] is set, base_we_out SHALL stay 0 in WB so the loaded value wins.
REQ-026 DONE SHALL last one cycle with done_out=1, then return to IDLE.
REQ-027 busy_out SHALL be 1 in XFER, WB and DONE, and 0 in IDLE.
REQ-028 start_in outside IDLE SHALL be ignored.
REQ-029 An empty list SHALL produce no memory or register writes and no writeback, with done_out one cycle after start.
REQ-030 Address arithmetic SHALL be modulo 2^32, wrapping silently.

Reset
REQ-031 While reset_in=0, the state SHALL be IDLE and all outputs 0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately: no further writes, no writeback, no done_out.
REQ-033 After reset_in deasserts, the first start_in SHALL be accepted on the next rising edge in IDLE.

Configuration
REQ-034 Macro LSM_BASE_WB_EN defined: WB state and base writeback behave per REQ-023..025.
REQ-035 Macro LSM_BASE_WB_EN undefined: the WB state is never entered, W is ignored, and base_we_out and base_wb_out are tied to 0.

Verification
REQ-036 STM, P=0 U=1, list 16'h000F, base 32'h100 -> addr 100,104,108,10C; we_out 1111 for 4 cycles; regs 0..3; done_out in cycle 5.
REQ-037 LDM, P=1 U=0, W=1, list 16'h8001, base 32'h200 -> addr 1F8,1FC; regs 0,15; reg_we_out 2 cycles; base_wb_out 1F8 strobed once (macro defined).
REQ-038 LDM, W=1, base_reg 3, list 16'h0008, base 32'h40 -> one load to r3 at 40; base_we_out stays 0.
REQ-039 Empty list, STM, W=1 -> no we_out, no base_we_out; busy 1 cycle; done_out 1 cycle after start.
REQ-040 Reset driven low in the 2nd XFER cycle of an 8-register STM -> outputs 0 immediately, no done_out; the next start runs a full transfer.
REQ-041 start_in held high during a transfer; base 32'hFFFFFFFC, U=1, P=1 -> extra starts ignored; first address wraps to 32'h00000000.
